// File: rtl/servo_pkg.sv
// Shared servo constants plus clamp and slew helpers.
// Also used by the backtrack stage for its slew stepping.
package servo_pkg;

  localparam int unsigned CLK_HZ_DEF    = 100_000_000;
  localparam int unsigned US_DIV        = CLK_HZ_DEF / 1_000_000;
  localparam int unsigned PERIOD_US_DEF = 20000;
  localparam int unsigned MIN_US_DEF    = 1000;
  localparam int unsigned MAX_US_DEF    = 2000;
  localparam int unsigned CENTER_US_DEF = 1500;
  localparam int unsigned SLEW_US_DEF   = 20;

  function automatic int unsigned us_div(
    input int unsigned clk_hz
  );
    return clk_hz / 1_000_000;
  endfunction

  function automatic int unsigned clamp_us(
    input int unsigned v,
    input int unsigned lo,
    input int unsigned hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // A step of zero means no limit.
  function automatic int unsigned slew_step(
    input int unsigned cur,
    input int unsigned tgt,
    input int unsigned step
  );
    if (step == 0) return tgt;
    if (tgt >= cur) begin
      if (tgt - cur <= step) return tgt;
      return cur + step;
    end
    if (cur - tgt <= step) return tgt;
    return cur - step;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: frame-synchronous clamped and slewed width.
// Produces a registered pulse that is high while us_cnt < width.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned VAL_W     = 11,
  parameter int unsigned CNT_W     = 15,
  parameter int unsigned MIN_US    = MIN_US_DEF,
  parameter int unsigned MAX_US    = MAX_US_DEF,
  parameter int unsigned CENTER_US = CENTER_US_DEF,
  parameter int unsigned SLEW_US   = SLEW_US_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             armed,
  input  logic             en,
  input  logic [CNT_W-1:0] us_cnt,
  input  logic [VAL_W-1:0] val,
  input  logic             inhibit,
  output logic             pwm,
  output logic [VAL_W-1:0] active
);

  logic [VAL_W-1:0] active_q;
  logic [VAL_W-1:0] active_d;
  logic [VAL_W-1:0] target;
  logic             pwm_q;
  logic             pwm_d;

  // Inhibit skips the slew limit so the servo recentres at once.
  always_comb begin
    target   = VAL_W'(clamp_us(32'(val), MIN_US, MAX_US));
    active_d = active_q;
    if (inhibit) target = VAL_W'(CENTER_US);
    if (frame) begin
      if (inhibit) active_d = target;
      else active_d = VAL_W'(slew_step(
        32'(active_q), 32'(target), SLEW_US));
    end
    pwm_d = armed && en
      && (32'(us_cnt) < 32'(active_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= VAL_W'(CENTER_US);
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm    = pwm_q;
  assign active = active_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel frame-synchronous servo PWM bank.
// Shared prescaler and us counter; widths change only at frame edges.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
  parameter int unsigned N_CH      = 3,
  parameter int unsigned VAL_W     = 11,
  parameter int unsigned PERIOD_US = PERIOD_US_DEF,
  parameter int unsigned MIN_US    = MIN_US_DEF,
  parameter int unsigned MAX_US    = MAX_US_DEF,
  parameter int unsigned CENTER_US = CENTER_US_DEF,
  parameter int unsigned SLEW_US   = SLEW_US_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_CH*VAL_W-1:0]   val,
  input  logic [N_CH-1:0]         inhibit,
  output logic [N_CH-1:0]         pwm,
  output logic                    frame_tick,
  output logic [N_CH*VAL_W-1:0]   width_out
);

  localparam int unsigned DIV   = us_div(CLK_HZ);
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W = $clog2(PERIOD_US);

  if (MAX_US >= PERIOD_US) begin : g_chk_period
    $error("MAX_US must be below PERIOD_US");
  end
  if (MIN_US > CENTER_US || CENTER_US > MAX_US) begin : g_chk_ctr
    $error("CENTER_US must lie within MIN_US..MAX_US");
  end
  if (MAX_US >= (64'd1 << VAL_W)) begin : g_chk_w
    $error("MAX_US does not fit in VAL_W bits");
  end
  if (CLK_HZ % 1_000_000 != 0 || DIV == 0) begin : g_chk_clk
    $error("CLK_HZ must be a nonzero multiple of 1 MHz");
  end

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             armed_q;
  logic             armed_d;
  logic             tick_q;
  logic             tick_d;
  logic             us_tick;
  logic             frame;

  assign us_tick = (pre_q == PRE_W'(DIV - 1));
  assign frame   = us_tick && (cnt_q == CNT_W'(PERIOD_US - 1));

  // Dropping en disarms, so a mid-frame re-enable waits a frame.
  always_comb begin
    pre_d   = us_tick ? '0 : pre_q + 1'b1;
    cnt_d   = cnt_q;
    if (frame) cnt_d = '0;
    else if (us_tick) cnt_d = cnt_q + 1'b1;
    armed_d = frame ? en : (armed_q & en);
    tick_d  = frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_channel #(
      .VAL_W     (VAL_W),
      .CNT_W     (CNT_W),
      .MIN_US    (MIN_US),
      .MAX_US    (MAX_US),
      .CENTER_US (CENTER_US),
      .SLEW_US   (SLEW_US)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .frame   (frame),
      .armed   (armed_q),
      .en      (en),
      .us_cnt  (cnt_q),
      .val     (val[i*VAL_W +: VAL_W]),
      .inhibit (inhibit[i]),
      .pwm     (pwm[i]),
      .active  (width_out[i*VAL_W +: VAL_W])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank on a shortened frame.
// 2 MHz clock, 300 us frame, 100..200 us clamp, centre 150, slew 20.
module tb_servo_pwm_bank;

  localparam int NC  = 3;
  localparam int VW  = 11;
  localparam int DIV = 2;
  localparam int PER = 300;
  localparam int FR  = DIV * PER;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [NC*VW-1:0]   val;
  logic [NC-1:0]      inhibit;
  logic [NC-1:0]      pwm;
  logic               frame_tick;
  logic [NC*VW-1:0]   width_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_pwm_bank #(
    .CLK_HZ    (2_000_000),
    .N_CH      (NC),
    .VAL_W     (VW),
    .PERIOD_US (PER),
    .MIN_US    (100),
    .MAX_US    (200),
    .CENTER_US (150),
    .SLEW_US   (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .val        (val),
    .inhibit    (inhibit),
    .pwm        (pwm),
    .frame_tick (frame_tick),
    .width_out  (width_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_val(input int c, input int v);
    val[c*VW +: VW] = VW'(v);
  endtask

  function automatic logic [NC*VW-1:0] pack3(
    input int a, input int b, input int c);
    return {VW'(c), VW'(b), VW'(a)};
  endfunction

  // Waits for the next frame_tick, requiring pwm to stay low.
  task automatic wait_tick(input string tag, input int exp_lat);
    int n  = 0;
    int hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (pwm !== '0) hi++;
    end while (frame_tick !== 1'b1 && n < FR + 50);
    chk({tag, "_tick"}, frame_tick, 1);
    chk({tag, "_silent"}, hi, 0);
    if (exp_lat > 0) chk({tag, "_lat"}, n, exp_lat);
  endtask

  // Called on a frame_tick cycle; measures one whole frame.
  task automatic measure(input string tag,
                         input int e0, input int e1, input int e2);
    int cnt [NC];
    int e   [NC];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    chk({tag, "_wout"}, width_out, pack3(e0, e1, e2));
    repeat (FR) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++)
        if (pwm[i] === 1'b1) cnt[i]++;
    end
    for (int i = 0; i < NC; i++)
      chk($sformatf("%s_ch%0d", tag, i), cnt[i], DIV * e[i]);
    chk({tag, "_next"}, frame_tick, 1);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    inhibit = '0;
    val     = pack3(150, 150, 150);
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_wout", width_out, pack3(150, 150, 150));
    rst = 1'b0;
    en  = 1'b1;
    wait_tick("boot", FR);

    measure("t1", 150, 150, 150);
    set_val(0, 200);
    measure("t2", 150, 150, 150);
    measure("t3", 170, 150, 150);
    measure("t4", 190, 150, 150);
    measure("t5", 200, 150, 150);

    set_val(0, 300);
    set_val(1, 0);
    set_val(2, 2047);
    measure("t6", 200, 150, 150);
    measure("t7", 200, 130, 170);
    measure("t8", 200, 110, 190);
    measure("t9", 200, 100, 200);

    set_val(2, 190);
    measure("t10", 200, 100, 200);
    inhibit[2] = 1'b1;
    measure("t11", 200, 100, 190);
    inhibit[2] = 1'b0;
    measure("t12", 200, 100, 150);
    measure("t13", 200, 100, 170);

    repeat (100) @(negedge clk);
    chk("en_hi_pwm", pwm, 3'b111);
    en = 1'b0;
    @(negedge clk);
    chk("en_lo_pwm", pwm, 0);
    repeat (200) @(negedge clk);
    en = 1'b1;
    wait_tick("en_re", FR - 301);
    measure("t15", 200, 100, 190);

    repeat (50) @(negedge clk);
    chk("pre_rst_pwm", pwm, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm", pwm, 0);
    chk("mid_rst_tick", frame_tick, 0);
    chk("mid_rst_wout", width_out, pack3(150, 150, 150));
    rst = 1'b0;
    wait_tick("post_rst", FR);
    measure("pr1", 170, 130, 170);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
